// File: rtl/game_ctrl_pkg.sv
// Shared state encoding and tick-period helper for the game control FSM
// and its tick divider.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RUN,
    UPDATE,
    WAIT_CMD,
    OVER,
    PAUSE
  } game_state_e;

  // Update period in clocks for a given difficulty level; higher levels are faster.
  function automatic logic [31:0] tick_period(input logic [31:0] lvl,
                                              input logic [31:0] base,
                                              input logic [31:0] step);
    return base - lvl * step;
  endfunction

endpackage

// File: rtl/game_tick_div.sv
// Loadable tick counter: counts while enabled, wraps to zero at period-1 and
// strobes tc_o in that cycle; clear_i forces the count back to zero.
module game_tick_div #(
  parameter int TICK_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [TICK_W-1:0] period_i,
  output logic              tc_o
);

  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              at_end;

  assign at_end = (cnt_q == period_i - TICK_W'(1));
  assign tc_o   = en_i & at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_end ? '0 : cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game control FSM: init draw, level select, timed play loop, update handshake
// and game-over reset. Optional pause is built when GAME_CTRL_PAUSE_EN is defined.
module game_ctrl_fsm
  import game_ctrl_pkg::*;
#(
  parameter int                NUM_LEVELS = 4,
  parameter int                TICK_W     = 24,
  parameter logic [TICK_W-1:0] BASE_TICKS = TICK_W'(5_000_000),
  parameter logic [TICK_W-1:0] TICK_STEP  = TICK_W'(1_000_000),
  localparam int               LVL_W      = $clog2(NUM_LEVELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_over,
  input  logic             cmd_done,
  input  logic             mode_pb,
  input  logic             start_pb,
  input  logic             pause_pb,
  output logic             init_cycle,
  output logic             enable_loop,
  output logic             en_update,
  output logic             sync_reset,
  output logic [LVL_W-1:0] level
);

  if (NUM_LEVELS < 2) begin : g_bad_levels
    $error("game_ctrl_fsm: NUM_LEVELS must be at least 2");
  end
  if (longint'(BASE_TICKS) - longint'(NUM_LEVELS - 1) * longint'(TICK_STEP) < 1) begin : g_bad_period
    $error("game_ctrl_fsm: fastest level period must be at least one clock");
  end

  game_state_e       state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              mode_q, start_q;
  logic              mode_edge, start_edge;
  logic              tick_clear, tick_en, tick_tc;
  logic [TICK_W-1:0] period;

  assign mode_edge  = mode_pb & ~mode_q;
  assign start_edge = start_pb & ~start_q;

`ifdef GAME_CTRL_PAUSE_EN
  logic pause_q;
  logic pause_edge;
  assign pause_edge = pause_pb & ~pause_q;
  always_ff @(posedge clk) begin
    if (rst) pause_q <= 1'b0;
    else     pause_q <= pause_pb;
  end
  // A pause request in the terminal-count cycle freezes the counter at period-1.
  assign tick_en = (state_q == RUN) & ~game_over & ~pause_edge;
`else
  logic unused_pause;
  assign unused_pause = pause_pb;
  assign tick_en      = (state_q == RUN) & ~game_over;
`endif

  assign tick_clear = (state_q == IDLE);
  assign period     = TICK_W'(tick_period(32'(level_q), 32'(BASE_TICKS), 32'(TICK_STEP)));

  game_tick_div #(.TICK_W(TICK_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tick_clear),
    .en_i     (tick_en),
    .period_i (period),
    .tc_o     (tick_tc)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      INIT:     if (cmd_done) state_d = IDLE;
      IDLE: begin
        if (start_edge) begin
          state_d = RUN;
        end else if (mode_edge) begin
          level_d = (level_q == LVL_W'(NUM_LEVELS - 1)) ? '0 : level_q + LVL_W'(1);
        end
      end
      RUN: begin
        if (game_over)       state_d = OVER;
`ifdef GAME_CTRL_PAUSE_EN
        else if (pause_edge) state_d = PAUSE;
`endif
        else if (tick_tc)    state_d = UPDATE;
      end
      UPDATE:   state_d = WAIT_CMD;
      WAIT_CMD: if (cmd_done) state_d = game_over ? OVER : RUN;
      OVER:     state_d = INIT;
`ifdef GAME_CTRL_PAUSE_EN
      PAUSE: begin
        if (game_over)       state_d = OVER;
        else if (pause_edge) state_d = RUN;
      end
`endif
      default:  state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      level_q <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      mode_q  <= mode_pb;
      start_q <= start_pb;
    end
  end

  assign init_cycle  = (state_q == INIT);
  assign enable_loop = (state_q == RUN) | (state_q == UPDATE) |
                       (state_q == WAIT_CMD) | (state_q == PAUSE);
  assign en_update   = (state_q == UPDATE);
  assign sync_reset  = (state_q == OVER);
  assign level       = level_q;

endmodule
